// File: rtl/pipe_stage_pkg.sv
// Shared types and constants for the elastic pipeline-stage register.
package pipe_stage_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam int CNT_W_DEFAULT = 16;

    // Width of one stored entry: control field above data field.
    function automatic int entry_width(input int ctrl_w, input int data_w);
        return ctrl_w + data_w;
    endfunction

endpackage

// File: rtl/pipe_stage_cnt.sv
// Saturating up-counter used for the stage statistics; state updates on the
// falling edge, cleared only by rst_n.
module pipe_stage_cnt
    import pipe_stage_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with one-entry skid, flush and NOP masking.
// Optional statistics counters are built when PIPE_STAGE_STATS_EN is defined.
module pipe_stage_reg
    import pipe_stage_pkg::*;
#(
    parameter int                CTRL_W         = 16,
    parameter int                DATA_W         = 96,
    parameter logic [CTRL_W-1:0] CTRL_KILL_MASK = '1,
    parameter int                CNT_W          = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam int ENTRY_W = entry_width(CTRL_W, DATA_W);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ENTRY_W-1:0] r_main;
    logic [ENTRY_W-1:0] r_skid;
    logic [ENTRY_W-1:0] w_in_entry;
    logic               w_accept;
    logic               w_take;
    logic               w_load_main_in;
    logic               w_load_main_skid;
    logic               w_load_skid;
    logic [CTRL_W-1:0]  w_main_ctrl;

    // Handshake flags depend on registered state only, so in_ready has no
    // combinational path from out_ready or in_valid.
    assign in_ready   = (r_state != TWO);
    assign out_valid  = (r_state != EMPTY);
    assign w_in_entry = {in_ctrl, in_data};
    assign w_accept   = in_valid & in_ready;
    assign w_take     = out_valid & out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        unique case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_state_nxt    = ONE;
                    w_load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (w_accept && w_take) begin
                    w_load_main_in = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = TWO;
                    w_load_skid = 1'b1;
                end else if (w_take) begin
                    w_state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (w_take) begin
                    w_state_nxt      = ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
        // Flush discards every event of this edge; stored data stays as-is.
        if (flush) begin
            w_state_nxt      = EMPTY;
            w_load_main_in   = 1'b0;
            w_load_main_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main <= w_in_entry;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_in_entry;
            end
        end
    end

    assign w_main_ctrl = r_main[ENTRY_W-1:DATA_W];
    assign out_data    = r_main[DATA_W-1:0];
    assign out_ctrl    = w_main_ctrl & ~(CTRL_KILL_MASK & {CTRL_W{~out_valid}});

`ifdef PIPE_STAGE_STATS_EN
    logic w_stall_inc;
    logic w_bubble_inc;

    assign w_stall_inc  = out_valid & ~out_ready;
    assign w_bubble_inc = ~out_valid;

    pipe_stage_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_stall_inc),
        .count (stall_cnt)
    );

    pipe_stage_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_bubble_inc),
        .count (bubble_cnt)
    );
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (falling-edge stage clock).
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_ctrl;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_ctrl;
    logic [15:0] out_data;
    logic [3:0]  stall_cnt;
    logic [3:0]  bubble_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    bit          bp_rdy  [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    bit          bp_irdy [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [15:0] bp_dat  [8] = '{16'h11, 16'h11, 16'h11, 16'h11,
                                 16'h12, 16'h13, 16'h14, 16'h15};

    pipe_stage_reg #(
        .CTRL_W         (8),
        .DATA_W         (16),
        .CTRL_KILL_MASK (8'h0F),
        .CNT_W          (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ctrl    (in_ctrl),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ctrl   (out_ctrl),
        .out_data   (out_data),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance past the next active (falling) edge and settle mid-low-phase.
    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic reset_pulse();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        rst_n     = 1'b1;
    endtask

    function automatic logic [63:0] cnt_exp(input int n);
        return STATS ? 64'(n) : 64'd0;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  nxt;
        bit  acc;
        rst_n     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;

        // Reset values, then idle bubbles
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_ctrl",  64'(out_ctrl),  64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_stall",     64'(stall_cnt), 64'd0);
        chk("rst_bubble",    64'(bubble_cnt), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_bubble1", 64'(bubble_cnt), cnt_exp(1));
        tick();
        tick();
        chk("idle_bubble3", 64'(bubble_cnt), cnt_exp(3));
        chk("idle_valid",   64'(out_valid),  64'd0);

        // Streaming, out_ready held high
        reset_pulse();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            in_data = 16'(k);
            in_ctrl = 8'(k);
            tick();
            chk("strm_data",  64'(out_data),  64'(k));
            chk("strm_ctrl",  64'(out_ctrl),  64'(k));
            chk("strm_valid", 64'(out_valid), 64'd1);
            chk("strm_ready", 64'(in_ready),  64'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("strm_drain_valid", 64'(out_valid), 64'd0);
        chk("strm_drain_ctrl",  64'(out_ctrl),  64'd0);
        chk("strm_drain_data",  64'(out_data),  64'h8);

        // Back-pressure: out_ready low for three edges
        reset_pulse();
        nxt      = 1;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            out_ready = bp_rdy[i];
            in_data   = 16'h10 + 16'(nxt);
            in_ctrl   = 8'hE0;
            acc       = in_ready;
            tick();
            if (acc) nxt++;
            chk("bp_data",     64'(out_data),  64'(bp_dat[i]));
            chk("bp_in_ready", 64'(in_ready),  64'(bp_irdy[i]));
            chk("bp_valid",    64'(out_valid), 64'd1);
        end
        chk("bp_stall_cnt", 64'(stall_cnt), cnt_exp(3));
        in_valid = 1'b0;

        // Flush while full, with a concurrent input
        reset_pulse();
        in_valid = 1'b1;
        in_ctrl  = 8'hA5;
        in_data  = 16'hB1;
        tick();
        in_ctrl  = 8'h5A;
        in_data  = 16'hB2;
        tick();
        chk("fl_two_in_ready", 64'(in_ready), 64'd0);
        in_ctrl  = 8'hC3;
        in_data  = 16'hB3;
        flush    = 1'b1;
        tick();
        chk("fl_valid",    64'(out_valid), 64'd0);
        chk("fl_in_ready", 64'(in_ready),  64'd1);
        chk("fl_ctrl",     64'(out_ctrl),  64'hA0);
        flush     = 1'b0;
        out_ready = 1'b1;
        in_ctrl   = 8'h3C;
        in_data   = 16'hB4;
        tick();
        chk("fl_next_data",  64'(out_data),  64'hB4);
        chk("fl_next_ctrl",  64'(out_ctrl),  64'h3C);
        chk("fl_next_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        tick();
        chk("fl_empty_valid", 64'(out_valid), 64'd0);

        // Asynchronous reset between edges
        reset_pulse();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_ctrl   = 8'h77;
        in_data   = 16'hC1;
        tick();
        chk("ar_pre_data", 64'(out_data), 64'hC1);
        rst_n = 1'b0;
        #1;
        chk("ar_valid",    64'(out_valid), 64'd0);
        chk("ar_in_ready", 64'(in_ready),  64'd1);
        chk("ar_ctrl",     64'(out_ctrl),  64'd0);
        chk("ar_data",     64'(out_data),  64'd0);
        rst_n   = 1'b1;
        in_ctrl = 8'h66;
        in_data = 16'hC2;
        tick();
        chk("ar_resume_data",  64'(out_data),  64'hC2);
        chk("ar_resume_ctrl",  64'(out_ctrl),  64'h66);
        chk("ar_resume_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b0;

        // Stall counter saturation at 4 bits
        reset_pulse();
        in_valid = 1'b1;
        in_ctrl  = 8'h11;
        in_data  = 16'hD1;
        tick();
        in_valid = 1'b0;
        repeat (18) tick();
        chk("sat_stall_15", 64'(stall_cnt), cnt_exp(15));
        repeat (2) tick();
        chk("sat_stall_hold", 64'(stall_cnt),  cnt_exp(15));
        chk("sat_bubble",     64'(bubble_cnt), cnt_exp(1));
        chk("sat_data",       64'(out_data),   64'hD1);
        chk("sat_valid",      64'(out_valid),  64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
